cpu_exec_unit: RTL
==================

// Module: cpu_exec_unit
// PURPOSE
//   Accumulator execute stage inside cpu_top. Consumes 8-bit instruction bytes from the external
//   control input via a valid/ready handshake. Executes them on accumulator A and register B.
//   Produces A (to the output mux) and flags {C,Z,V,N} (to the status pins).
//   Shift and multiply instructions are multi-cycle and iterative.
// PARAMETERS
//   DATA_W   8   datapath width; opcode/immediate split stays 4/4
//   MUL_EN   1   1: MUL implemented; 0: MUL decodes as NOP
// PORTS
//   clk_i          in   1       single clock, rising edge
//   rst_ni         in   1       synchronous, active-low reset
//   instr_i        in   8       [7:4] opcode, [3:0] imm4
//   instr_valid_i  in   1       instr_i valid this cycle
//   instr_ready_o  out  1       unit can accept; transfer = valid & ready at rising edge
//   result_o       out  DATA_W  accumulator A
//   breg_o         out  DATA_W  register B
//   flags_o        out  4       {C,Z,V,N} = [3:0]
//   busy_o         out  1       multi-cycle op in progress (= ~instr_ready_o)
// BEHAVIOUR
//   Reset: next edge with rst_ni=0 -> A=0, B=0, flags=4'b0100 (Z=1), state IDLE, ready=1, busy=0.
//     Aborts any shift/mul in progress; no partial result is kept.
//   Opcodes:
//     0 NOP
//     1 LDL A[3:0]=imm
//     2 LDH A[7:4]=imm
//     3 MOV B=A
//     4 ADD A=A+B
//     5 SUB A=A-B
//     6 AND
//     7 OR
//     8 XOR
//     9 SHL A<<=imm
//     A SHR A>>=imm (logical)
//     B MUL {B,A}=A*B (unsigned)
//     C INC A=A+1
//     D CMP (flags of A-B; A unchanged)
//     E,F reserved = NOP
//   Flags:
//     NOP/LDL/LDH/MOV/reserved leave all flags unchanged.
//     Every other op sets Z=(A_new==0) and N=A_new[7]. For CMP, Z and N are computed from A-B.
//     ADD/INC: C=carry-out, V=signed overflow.
//     SUB/CMP: C=borrow (A<B unsigned), V=signed overflow.
//     AND/OR/XOR: C=0, V=0.
//     SHL/SHR: C=last bit shifted out, V=0.
//     MUL: C=(B_new!=0), V=0; Z and N are taken from A_new (low byte).
//   FSM IDLE/SHIFT/MUL:
//     IDLE, single-cycle op accepted -> A/B/flags update on that edge; stay IDLE.
//       Throughput 1 instr/cycle.
//     IDLE, SHL/SHR with imm=n>=1 -> SHIFT with cnt=n. Each SHIFT edge shifts 1 bit and decrements cnt.
//       When cnt reaches 0 -> IDLE. ready is low for exactly n cycles.
//     SHL/SHR with imm=0 -> single cycle; A unchanged, C=0, V=0, Z/N updated.
//     IDLE, MUL (MUL_EN=1) -> MUL: shift-add over 8 edges, then IDLE. ready is low for exactly 8 cycles.
//       A/B hold intermediates during MUL. Final {B,A} is valid when ready returns high.
//   instr_valid_i while ready=0: not accepted. Upstream must hold instr_i/valid until accepted.
//     No buffering inside the unit.
//   Arithmetic wraps modulo 2^DATA_W. Shift counts >= DATA_W clear A.
//     C = last bit out; for a count > DATA_W, C=0.
// STRUCTURE
//   cpu_pkg: opcode localparams/enum, flag bit indices (FLAG_C=3,FLAG_Z=2,FLAG_V=1,FLAG_N=0),
//     FSM state encoding.
//   Sub-module cpu_alu: combinational single-cycle ops + flag generation.
//     The shift/mul sequencer and registers stay in cpu_exec_unit.
// TESTING
//   1 Reset with A=0x5A mid-MUL -> next cycle A=0, B=0, flags=0100, ready=1.
//   2 LDH 7, LDL F, MOV, ADD (A=B=0x7F) -> A=0xFE, flags C=0,Z=0,V=1,N=1. One instr/cycle, ready never drops.
//   3 A=0x00, B=0x01, SUB -> A=0xFF, C=1, Z=0, V=0, N=1. CMP with A=B=0x33 -> A=0x33, Z=1, C=0.
//   4 A=0x81, SHL 3 -> ready low 3 cycles; A=0x08, C=0 (last bit out = bit5 = 0), Z=0, N=0.
//     SHR 0 -> single cycle, C=0.
//   5 A=0xFF, B=0xFF, MUL -> ready low 8 cycles; then A=0x01, B=0xFE, C=1, Z=0, N=0.
//   6 valid held high with a new ADD during SHIFT -> ADD not executed until ready=1, then executed exactly once.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, flag bit positions, sequencer states and flag packing shared by the execute stage
package cpu_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_LDL, OP_LDH, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
    OP_XOR, OP_SHL, OP_SHR, OP_MUL, OP_INC, OP_CMP, OP_RSV_E, OP_RSV_F
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_e;
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;
  localparam logic [3:0] FLAGS_RST = 4'b1 << FLAG_Z;
  function automatic logic [3:0] mk_flags(input logic c, input logic z, input logic v, input logic n);
    mk_flags = '0;
    mk_flags[FLAG_C] = c;
    mk_flags[FLAG_Z] = z;
    mk_flags[FLAG_V] = v;
    mk_flags[FLAG_N] = n;
  endfunction
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational single-cycle ops and flag generation
//   op/imm      decoded instruction
//   a/b/flags   current A, B, {C,Z,V,N}
//   a_nxt/b_nxt/flags_nxt  values to load when the op retires in one cycle
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  op_e               op,
  input  logic [3:0]        imm,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        flags,
  output logic [DATA_W-1:0] a_nxt,
  output logic [DATA_W-1:0] b_nxt,
  output logic [3:0]        flags_nxt
);
  localparam int M = DATA_W - 1;
  logic [DATA_W:0] add, sub, inc;
  logic [DATA_W-1:0] res;
  logic c, v, upd;
  assign add = {1'b0, a} + {1'b0, b};
  assign sub = {1'b0, a} - {1'b0, b};
  assign inc = {1'b0, a} + (DATA_W+1)'(1);
  always_comb begin
    a_nxt = a;
    b_nxt = b;
    res = a;
    c = 1'b0;
    v = 1'b0;
    upd = 1'b1;
    case (op)
      OP_LDL: begin a_nxt[3:0] = imm; upd = 1'b0; end
      OP_LDH: begin a_nxt[7:4] = imm; upd = 1'b0; end
      OP_MOV: begin b_nxt = a; upd = 1'b0; end
      OP_ADD: begin
        {c, res} = add;
        v = (a[M] == b[M]) && (res[M] != a[M]);
        a_nxt = res;
      end
      OP_SUB, OP_CMP: begin
        // bit DATA_W of the widened difference is the unsigned borrow
        {c, res} = sub;
        v = (a[M] != b[M]) && (res[M] != a[M]);
        a_nxt = op == OP_SUB ? res : a;
      end
      OP_AND: begin res = a & b; a_nxt = res; end
      OP_OR:  begin res = a | b; a_nxt = res; end
      OP_XOR: begin res = a ^ b; a_nxt = res; end
      // only zero-count shifts retire here; nonzero counts go to the sequencer
      OP_SHL, OP_SHR: res = a;
      OP_INC: begin
        {c, res} = inc;
        v = ~a[M] & res[M];
        a_nxt = res;
      end
      default: upd = 1'b0;
    endcase
    flags_nxt = upd ? mk_flags(c, res == '0, v, res[M]) : flags;
  end
endmodule

// File: rtl/cpu_exec_unit.sv
// cpu_exec_unit: accumulator execute stage with iterative shift and multiply
//   clk_i, rst_ni        clock, synchronous active-low reset
//   instr_i/valid/ready  instruction byte handshake ([7:4] opcode, [3:0] imm4)
//   result_o, breg_o     accumulator A, register B
//   flags_o              {C,Z,V,N}
//   busy_o               multi-cycle op in progress
module cpu_exec_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        instr_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] breg_o,
  output logic [3:0]        flags_o,
  output logic              busy_o
);
  localparam int M = DATA_W - 1;
  state_e state, state_nxt;
  op_e op;
  logic [3:0] imm, f, alu_f;
  logic [DATA_W-1:0] a, b, mcand, alu_a, alu_b, sh_a;
  logic [DATA_W:0] psum;
  logic [2*DATA_W-1:0] prod;
  logic [7:0] cnt;
  logic left, sh_c, accept, is_shift, is_mul;
  assign op = op_e'(instr_i[7:4]);
  assign imm = instr_i[3:0];
  assign instr_ready_o = state == S_IDLE;
  assign busy_o = ~instr_ready_o;
  assign accept = instr_valid_i & instr_ready_o;
  assign is_shift = (op == OP_SHL || op == OP_SHR) && imm != 4'd0;
  assign is_mul = MUL_EN && op == OP_MUL;
  assign result_o = a;
  assign breg_o = b;
  assign flags_o = f;
  assign sh_c = left ? a[M] : a[0];
  assign sh_a = left ? a << 1 : a >> 1;
  // shift-add step: {B,A} holds {partial product, remaining multiplier bits}
  assign psum = {1'b0, b} + (a[0] ? {1'b0, mcand} : '0);
  assign prod = {psum, a[M:1]};
  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op(op), .imm(imm), .a(a), .b(b), .flags(f),
    .a_nxt(alu_a), .b_nxt(alu_b), .flags_nxt(alu_f)
  );
  always_comb begin
    state_nxt = state;
    state_nxt = state == S_IDLE ? (accept && is_shift ? S_SHIFT : accept && is_mul ? S_MUL : S_IDLE)
              : cnt == 8'd1 ? S_IDLE : state;
  end
  always_ff @(posedge clk_i)
    state <= !rst_ni ? S_IDLE : state_nxt;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a <= '0;
      b <= '0;
      f <= FLAGS_RST;
      mcand <= '0;
      cnt <= '0;
      left <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (is_shift) begin
            cnt <= 8'(imm);
            left <= op == OP_SHL;
          end else if (is_mul) begin
            cnt <= 8'(DATA_W);
            mcand <= b;
            b <= '0;
          end else begin
            a <= alu_a;
            b <= alu_b;
            f <= alu_f;
          end
        end
        S_SHIFT: begin
          a <= sh_a;
          f <= mk_flags(sh_c, sh_a == '0, 1'b0, sh_a[M]);
          cnt <= cnt - 8'd1;
        end
        S_MUL: begin
          {b, a} <= prod;
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) f <= mk_flags(prod[2*DATA_W-1:DATA_W] != '0, prod[M:0] == '0, 1'b0, prod[M]);
        end
        default: ;
      endcase
    end
  end
endmodule
